la_arbmux3: RTL and testbench
=============================

# la_arbmux3

Three-requester round-robin packet arbiter that owns the select lines of a 3:1 inverting mux datapath (s0/s1 encoding: d0 = s1:0 s0:0, d1 = s1:0 s0:1, d2 = s1:1 s0:0). It accepts valid/ready/last streams on three inputs and locks the grant for a whole packet. It forwards one stream through a registered output stage. It sits wherever several producers share one narrow link built from la_muxi3 cells.

## Interface
- DW, 8, data width per requester and output
- PROP, "DEFAULT", implementation property passed to datapath cells
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  3  per-requester beat valid
- in_last  in  3  per-requester end-of-packet flag, qualified by in_valid
- in_data  in  3*DW  requester data; requester k at [k*DW +: DW]
- in_ready  out  3  per-requester beat accept
- out_valid  out  1  output beat valid (registered)
- out_last  out  1  output end-of-packet (registered)
- out_data  out  DW  output data (registered, true polarity)
- out_ready  in  1  downstream accept
- grant  out  3  one-hot current owner, 000 when none
- s0, s1  out  1 each  mux select, encoding above

## Operation
- Reset values: state IDLE, ptr 0, grant 000, s0 0, s1 0, in_ready 000, out_valid 0, out_last 0, out_data 0.
- States: IDLE and LOCK.
- IDLE: in_ready 000. If any in_valid is set, the winner is the first set bit scanning ptr, ptr+1, ptr+2 (mod 3).
  - Next cycle: grant ← one-hot(winner), s1/s0 ← encoding(winner), state ← LOCK.
  - If no in_valid is set: stay in IDLE; grant, s0 and s1 hold their previous values.
- LOCK, owner g:
  - in_ready[g] = ~out_valid | out_ready. Other in_ready bits are 0.
  - Transfer when in_valid[g] & in_ready[g]: out_data ← selected data, out_last ← in_last[g], out_valid ← 1.
  - Transfer with in_last[g]=1: state ← IDLE, grant ← 000, ptr ← (g+1) mod 3. s0/s1 hold their values.
- Output register:
  - out_valid clears on out_ready with no new transfer.
  - out_data and out_last are held while out_valid & ~out_ready.
- The grant is locked for the whole packet. Deassertion of in_valid[g] mid-packet does not release it; the controller waits indefinitely.
- Datapath: DW la_muxi3 slices driven by s0/s1, followed by an inverter per bit ahead of the output register. out_data equals in_data of the owner bit-exactly.
- ptr values are only 0, 1 or 2. Wrap is g=2 → ptr 0.
- Reset mid-packet aborts the packet. All outputs return to reset values; the partial packet is not completed.

## Timing
- Arbitration costs one cycle: a request visible in IDLE at edge n gives grant at n+1 and the first in_ready at n+1.
- Beat latency: input transfer at edge n → out_valid/out_data at n+1.
- Within a packet, throughput is 1 beat/cycle while out_ready stays high.
- Between packets there is at least one bubble cycle (the IDLE arbitration cycle).
- in_ready depends combinationally on out_ready and the registered state only. There is no path from in_valid to in_ready.
- s0/s1 are registered and glitch-free. They change only on the IDLE→LOCK edge.

## Structure
- Shared package la_arb_pkg:
  - state encoding localparams (IDLE=0, LOCK=1)
  - select encoding localparams SEL_D0=2'b00, SEL_D1=2'b01, SEL_D2=2'b10 (as {s1,s0})
- Sub-module la_rr3_pick (combinational): inputs req[2:0], ptr[1:0]; outputs winner one-hot[2:0] and any.
- Top: FSM, ptr, grant/select registers, output register, DW instances of la_muxi3 with PROP passed through.

## Test plan
- Reset with all in_valid=111 held through reset release → grant=001, s1s0=00 one cycle after release; in_ready=001 in that cycle.
- All three requesters send single-beat packets continuously, out_ready=1 → grant sequence 001, 010, 100, 001; out_data order d0, d1, d2, d0; one bubble between beats.
- Requester 1 sends a 4-beat packet 0x11..0x14 while requester 0 is valid, out_ready=1 → four consecutive outputs 0x11..0x14 with last on 0x14; in_ready[0]=0 throughout; grant then moves to requester 0 (ptr=2 wraps).
- out_ready=0 for 3 cycles mid-packet → out_data/out_last stable, in_ready[g]=0 after the first buffered beat, no beat lost or duplicated after out_ready returns.
- Owner drops in_valid for 5 cycles mid-packet while the others request → grant unchanged, s0/s1 unchanged, packet resumes intact.
- Assert reset during LOCK with out_valid=1 → same cycle: out_valid=0, grant=000, in_ready=000; after release, arbitration restarts from ptr 0.

Source files
------------

// File: rtl/la_arb_pkg.sv
// Shared encodings for the la_arbmux3 round-robin packet arbiter.
// The arbiter FSM and the datapath select logic both import this package.
package la_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Mux select codes, given as {s1,s0}
    localparam logic [1:0] SEL_D0 = 2'b00;
    localparam logic [1:0] SEL_D1 = 2'b01;
    localparam logic [1:0] SEL_D2 = 2'b10;

    function automatic logic [1:0] sel_of(input logic [2:0] oh);
        sel_of = oh[2] ? SEL_D2 : (oh[1] ? SEL_D1 : SEL_D0);
    endfunction

    // The pointer moves to the requester after the one that just finished; 2 wraps to 0
    function automatic logic [1:0] ptr_after(input logic [2:0] oh);
        ptr_after = oh[0] ? 2'd1 : (oh[1] ? 2'd2 : 2'd0);
    endfunction

endpackage

// File: rtl/la_muxi3.sv
// 3:1 inverting mux cell: z = ~d0 / ~d1 / ~d2 for {s1,s0} = 00 / 01 / 1x.
module la_muxi3 #(
    parameter PROP = "DEFAULT"
) (
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic s0,
    input  logic s1,
    output logic z
);

    // Non-default properties map to the same behavioural cell in this library
    if (PROP == "DEFAULT") begin : g_default
        assign z = ~(s1 ? d2 : (s0 ? d1 : d0));
    end else begin : g_prop
        assign z = ~(s1 ? d2 : (s0 ? d1 : d0));
    end

endmodule

// File: rtl/la_rr3_pick.sv
// Combinational 3-way round-robin pick: the first set req bit scanning ptr, ptr+1, ptr+2 (mod 3).
module la_rr3_pick (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] winner,
    output logic       any
);

    logic [2:0] w_rot;
    logic [2:0] w_pick;

    // Rotate so that bit 0 is the requester at ptr, pick the lowest bit, then rotate back
    always_comb begin
        case (ptr)
            2'd1:    w_rot = {req[0], req[2:1]};
            2'd2:    w_rot = {req[1:0], req[2]};
            default: w_rot = req;
        endcase
    end

    always_comb begin
        if (w_rot[0])      w_pick = 3'b001;
        else if (w_rot[1]) w_pick = 3'b010;
        else if (w_rot[2]) w_pick = 3'b100;
        else               w_pick = 3'b000;
    end

    always_comb begin
        case (ptr)
            2'd1:    winner = {w_pick[1:0], w_pick[2]};
            2'd2:    winner = {w_pick[0], w_pick[2:1]};
            default: winner = w_pick;
        endcase
    end

    assign any = |req;

endmodule

// File: rtl/la_arbmux3.sv
// Three-requester round-robin packet arbiter driving a la_muxi3 datapath.
// The grant is held for a whole packet; the selected stream goes through one output register.
module la_arbmux3
    import la_arb_pkg::*;
#(
    parameter int DW   = 8,
    parameter     PROP = "DEFAULT"
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      in_valid,
    input  logic [2:0]      in_last,
    input  logic [3*DW-1:0] in_data,
    output logic [2:0]      in_ready,
    output logic            out_valid,
    output logic            out_last,
    output logic [DW-1:0]   out_data,
    input  logic            out_ready,
    output logic [2:0]      grant,
    output logic            s0,
    output logic            s1
);

    arb_state_t      r_state, w_state_nx;
    logic [1:0]      r_ptr, w_ptr_nx;
    logic [2:0]      r_grant, w_grant_nx;
    logic [1:0]      r_sel, w_sel_nx;
    logic            r_out_valid;
    logic            r_out_last;
    logic [DW-1:0]   r_out_data;

    logic [2:0]      w_winner;
    logic            w_any;
    logic [2:0]      w_in_ready;
    logic            w_xfer;
    logic            w_own_last;
    logic [DW-1:0]   w_muxn;
    logic [DW-1:0]   w_sel_data;

    la_rr3_pick u_pick (
        .req    (in_valid),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    assign w_own_last = |(in_last & r_grant);

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_grant_nx = r_grant;
        w_sel_nx   = r_sel;
        w_in_ready = 3'b000;
        w_xfer     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_nx = w_winner;
                    w_sel_nx   = sel_of(w_winner);
                    w_state_nx = LOCK;
                end
            end
            LOCK: begin
                // Ready only from registered state and out_ready; never from in_valid
                w_in_ready = r_grant & {3{~r_out_valid | out_ready}};
                w_xfer     = |(in_valid & w_in_ready);
                if (w_xfer && w_own_last) begin
                    w_state_nx = IDLE;
                    w_grant_nx = 3'b000;
                    w_ptr_nx   = ptr_after(r_grant);
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_grant <= 3'b000;
            r_sel   <= SEL_D0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_grant <= w_grant_nx;
            r_sel   <= w_sel_nx;
        end
    end

    for (genvar b = 0; b < DW; b++) begin : g_mux
        la_muxi3 #(.PROP(PROP)) u_mux (
            .d0 (in_data[b]),
            .d1 (in_data[DW+b]),
            .d2 (in_data[2*DW+b]),
            .s0 (r_sel[0]),
            .s1 (r_sel[1]),
            .z  (w_muxn[b])
        );
    end

    // The mux cells invert, so restore true polarity ahead of the register
    assign w_sel_data = ~w_muxn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_own_last;
            r_out_data  <= w_sel_data;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign grant     = r_grant;
    assign s1        = r_sel[1];
    assign s0        = r_sel[0];

endmodule

// File: tb/tb_la_arbmux3.sv
// Randomized bench for la_arbmux3: per-requester packet queues feed the DUT, and an
// integer-level arbitration model predicts every output cycle by cycle.
module tb_la_arbmux3;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      in_valid;
    logic [2:0]      in_last;
    logic [3*DW-1:0] in_data;
    logic [2:0]      in_ready;
    logic            out_valid;
    logic            out_last;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [2:0]      grant;
    logic            s0;
    logic            s1;

    always #5 clk = ~clk;

    la_arbmux3 #(.DW(DW), .PROP("DEFAULT")) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant     (grant),
        .s0        (s0),
        .s1        (s1)
    );

    typedef struct packed {
        logic          l;
        logic [DW-1:0] d;
    } beat_t;

    beat_t q [3][$];

    int n_chk  = 0;
    int n_fail = 0;
    int n_push = 0;
    int n_out  = 0;

    // Reference model: owner -1 means nobody holds the link
    int            m_own;
    int            m_ptr;
    int            m_sel;
    bit            m_ov;
    bit            m_ol;
    logic [DW-1:0] m_od;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own = -1;
        m_ptr = 0;
        m_sel = 0;
        m_ov  = 0;
        m_ol  = 0;
        m_od  = '0;
    endtask

    task automatic push_pkt(input int k, input int len, input logic [DW-1:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.l = (i == len - 1);
            b.d = base + DW'(i);
            q[k].push_back(b);
        end
        n_push += len;
    endtask

    // Called at a negedge: drive, check, advance the model, return at the next negedge
    task automatic step(input logic [2:0] v, input logic [2:0] l, input logic [3*DW-1:0] d,
                        input logic ordy, output logic [2:0] acc);
        logic [2:0] erdy;
        bit         rdy;
        int         k;
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        out_ready = ordy;
        #1;
        rdy  = (m_own >= 0) && (!m_ov || ordy);
        erdy = rdy ? 3'(1 << m_own) : 3'b000;
        chk("grant", 32'(grant), (m_own < 0) ? 32'd0 : 32'(1 << m_own));
        chk("sel", 32'({s1, s0}), m_sel);
        chk("in_ready", 32'(in_ready), 32'(erdy));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_last", 32'(out_last), 32'(m_ol));
        chk("out_data", 32'(out_data), 32'(m_od));
        if (out_valid && ordy) n_out++;
        acc = 3'b000;
        if (m_own < 0) begin
            if (ordy) m_ov = 0;
            for (int i = 0; i < 3; i++) begin
                k = (m_ptr + i) % 3;
                if (v[k] && m_own < 0) begin
                    m_own = k;
                    m_sel = k;
                end
            end
        end else if (rdy && v[m_own]) begin
            acc[m_own] = 1'b1;
            m_ov = 1;
            m_ol = l[m_own];
            m_od = d[m_own*DW +: DW];
            if (l[m_own]) begin
                m_ptr = (m_own + 1) % 3;
                m_own = -1;
            end
        end else if (ordy) begin
            m_ov = 0;
        end
        @(negedge clk);
    endtask

    task automatic run(input int ncyc, input int vpct, input int rpct, input logic [2:0] mute);
        logic [2:0]      v;
        logic [2:0]      l;
        logic [2:0]      acc;
        logic [3*DW-1:0] d;
        logic            ordy;
        for (int c = 0; c < ncyc; c++) begin
            for (int k = 0; k < 3; k++) begin
                v[k] = (q[k].size() > 0) && !mute[k] && (int'($urandom_range(99)) < vpct);
                d[k*DW +: DW] = v[k] ? q[k][0].d : DW'($urandom);
                l[k] = v[k] ? q[k][0].l : 1'($urandom);
            end
            ordy = (int'($urandom_range(99)) < rpct);
            step(v, l, d, ordy, acc);
            for (int k = 0; k < 3; k++)
                if (acc[k]) void'(q[k].pop_front());
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((q[0].size() + q[1].size() + q[2].size() > 0 || m_own >= 0 || m_ov) && c < 300) begin
            run(1, 100, 100, 3'b000);
            c++;
        end
        chk("drain", 32'(c < 300), 32'd1);
    endtask

    // Called at a negedge; asserts reset, checks the reset outputs at once, releases at a negedge
    task automatic do_reset(input logic [2:0] v);
        reset     = 1'b1;
        in_valid  = v;
        in_last   = 3'b000;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sel", 32'({s1, s0}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 3'b000;
        in_last   = 3'b000;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();
        @(negedge clk);

        // All three requesting through reset release, then continuous single beats
        push_pkt(0, 1, 8'hA0);
        push_pkt(1, 1, 8'hB1);
        push_pkt(2, 1, 8'hC2);
        push_pkt(0, 1, 8'hA3);
        do_reset(3'b111);
        run(12, 100, 100, 3'b000);
        drain();

        // Four-beat packet on requester 1 while requester 0 waits
        push_pkt(1, 4, 8'h11);
        push_pkt(0, 1, 8'h55);
        run(12, 100, 100, 3'b000);
        drain();

        // Downstream stall mid-packet
        push_pkt(2, 6, 8'h60);
        run(3, 100, 100, 3'b000);
        run(3, 100, 0, 3'b000);
        drain();

        // Owner goes quiet for five cycles while the others request
        push_pkt(0, 6, 8'h70);
        push_pkt(1, 1, 8'h7A);
        push_pkt(2, 1, 8'h7B);
        run(3, 100, 100, 3'b000);
        run(5, 100, 100, (m_own >= 0) ? 3'(1 << m_own) : 3'b000);
        drain();
        chk("beats_directed", 32'(n_out), 32'(n_push));

        // Reset while a packet is in flight with a beat in the output register
        push_pkt(1, 8, 8'h80);
        run(4, 100, 100, 3'b000);
        chk("lock_before_reset", 32'(m_own >= 0 && m_ov), 32'd1);
        for (int k = 0; k < 3; k++) q[k].delete();
        n_push = 0;
        n_out  = 0;
        push_pkt(0, 1, 8'h90);
        push_pkt(1, 1, 8'h91);
        push_pkt(2, 1, 8'h92);
        do_reset(3'b111);
        run(4, 100, 100, 3'b000);
        drain();

        // Random traffic, random gaps and backpressure
        for (int it = 0; it < 400; it++) begin
            for (int k = 0; k < 3; k++)
                if (q[k].size() < 4 && $urandom_range(1) == 1)
                    push_pkt(k, int'($urandom_range(5, 1)), DW'($urandom));
            run(5, 70, 70, 3'b000);
        end
        drain();
        chk("beats_total", 32'(n_out), 32'(n_push));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
